m_bridge: RTL and testbench

- Data-side bus bridge between the core's M stage and a variable-latency data memory/device port.
- Converts single-cycle core load/store requests into a req/ack memory handshake.
- Posts stores through a one-entry write buffer; stalls the core while a load or a blocked store is outstanding.
- Bounds every memory transaction with a wait-cycle timeout.

---
 rtl/m_bridge.sv | 192 +++++++++++++++++++
 tb/tb_m_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_bridge.sv
// m_bridge: M-stage load/store to req/ack memory bridge with a one-entry posted write buffer and transaction timeout.
// Optional store-to-load forwarding from the write buffer when M_BRIDGE_FWD_EN is defined.
module m_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_be,
  input  logic        m_we,
  input  logic        m_rd,
  output logic [31:0] m_rdata,
  output logic        m_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state, state_nxt;
  logic        wb_valid, wb_valid_nxt;
  logic [31:0] wb_addr, wb_addr_nxt;
  logic [31:0] wb_data, wb_data_nxt;
  logic [3:0]  wb_be, wb_be_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        fwd_q, fwd_nxt;
  logic        bus_err_nxt;
  logic        mem_req_nxt, mem_we_nxt;
  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_be_nxt;

  logic        wr_ack, st_acc, ld_req, timeout_hit, fwd_hit;
  logic [31:0] word_addr;
  logic        unused_addr_lo;

  assign word_addr      = {m_addr[31:2], 2'b00};
  assign unused_addr_lo = ^m_addr[1:0];
  assign wr_ack         = (state == S_WR) && mem_ack;
  assign st_acc         = m_we && (!wb_valid || wr_ack);
  assign ld_req         = m_rd && !m_we;
  assign timeout_hit    = !mem_ack && (cnt == CNT_LAST);
  assign m_rdata        = rdata_q;

`ifdef M_BRIDGE_FWD_EN
  // Full-word buffered store to the same word answers the load without a memory read.
  assign fwd_hit = ld_req && !fwd_q && wb_valid && (wb_be == 4'b1111) &&
                   (wb_addr[31:2] == m_addr[31:2]) && ((state == S_IDLE) || (state == S_WR));
`else
  assign fwd_hit = 1'b0;
`endif

  // Core stall: stores wait for a free buffer, loads wait for data.
  always_comb begin
    m_stall = 1'b0;
    if (m_we) begin
      m_stall = !st_acc;
    end else if (m_rd) begin
      m_stall = !((state == S_DONE) || fwd_q);
    end
  end

  // Next state and next register values.
  always_comb begin
    state_nxt     = state;
    wb_valid_nxt  = wb_valid;
    wb_addr_nxt   = wb_addr;
    wb_data_nxt   = wb_data;
    wb_be_nxt     = wb_be;
    cnt_nxt       = cnt;
    rdata_nxt     = rdata_q;
    fwd_nxt       = 1'b0;
    bus_err_nxt   = bus_err;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;

    if (fwd_hit) begin
      fwd_nxt   = 1'b1;
      rdata_nxt = wb_data;
    end

    case (state)
      S_IDLE: begin
        // Drain before any load so memory sees stores in program order.
        if (wb_valid) begin
          state_nxt     = S_WR;
          cnt_nxt       = 8'd0;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = wb_addr;
          mem_wdata_nxt = wb_data;
          mem_be_nxt    = wb_be;
        end else if (ld_req && !fwd_q) begin
          state_nxt    = S_RD;
          cnt_nxt      = 8'd0;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = word_addr;
          mem_be_nxt   = 4'b0000;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_nxt    = S_IDLE;
          mem_req_nxt  = 1'b0;
          wb_valid_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (timeout_hit) begin
            state_nxt    = S_IDLE;
            mem_req_nxt  = 1'b0;
            wb_valid_nxt = 1'b0;
            bus_err_nxt  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          state_nxt   = S_DONE;
          mem_req_nxt = 1'b0;
          rdata_nxt   = mem_rdata;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (timeout_hit) begin
            state_nxt   = S_DONE;
            mem_req_nxt = 1'b0;
            rdata_nxt   = 32'h0000_0000;
            bus_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Capture overrides the drain clear when a store lands on the ack edge.
    if (st_acc) begin
      wb_valid_nxt = 1'b1;
      wb_addr_nxt  = word_addr;
      wb_data_nxt  = m_wdata;
      wb_be_nxt    = m_be;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_be     <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      fwd_q     <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state     <= state_nxt;
      wb_valid  <= wb_valid_nxt;
      wb_addr   <= wb_addr_nxt;
      wb_data   <= wb_data_nxt;
      wb_be     <= wb_be_nxt;
      cnt       <= cnt_nxt;
      rdata_q   <= rdata_nxt;
      fwd_q     <= fwd_nxt;
      bus_err   <= bus_err_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_be    <= mem_be_nxt;
    end
  end

endmodule

// File: tb/tb_m_bridge.sv
// tb_m_bridge: self-checking bench for m_bridge with a variable-latency memory responder,
// a directed vector table, corner-case sequences and random traffic against a memory model.
module tb_m_bridge;

  localparam int unsigned TO = 4;
  localparam int LIMIT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_we, m_rd, m_stall;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  m_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_we(m_we), .m_rd(m_rd),
    .m_rdata(m_rdata), .m_stall(m_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h1234_5678;
    if (i == 8) return 32'h0000_0000;
    return 32'hD000_0000 | 32'(i);
  endfunction

  // Memory responder: acks once a request has waited ack_delay cycles.
  logic [31:0] mem [0:63];
  int          ack_delay = 0;
  int          wait_cnt, cyc, rd_starts, last_rd_start_cyc, last_wr_ack_cyc, last_len;
  logic        prev_req, last_we;
  logic [31:0] last_addr;
  logic [3:0]  last_be;

  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      wait_cnt <= 0; cyc <= 0; rd_starts <= 0; prev_req <= 1'b0;
      last_rd_start_cyc <= 0; last_wr_ack_cyc <= 0; last_len <= 0;
      last_we <= 1'b0; last_addr <= '0; last_be <= '0;
    end else begin
      cyc      <= cyc + 1;
      prev_req <= mem_req;
      wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
      if (mem_req && !prev_req && !mem_we) begin
        rd_starts         <= rd_starts + 1;
        last_rd_start_cyc <= cyc;
      end
      if (mem_ack) begin
        last_len  <= wait_cnt + 1;
        last_addr <= mem_addr;
        last_we   <= mem_we;
        last_be   <= mem_be;
        if (mem_we) begin
          last_wr_ack_cyc <= cyc;
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request fields must not move while a request waits for its ack.
  logic        hold;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;
  logic [3:0]  h_be;
  int          stable_err = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= 1'b0;
    end else begin
      if (hold && mem_req && ((mem_addr != h_addr) || (mem_we != h_we) || (mem_be != h_be) ||
                              (h_we && (mem_wdata != h_wdata))))
        stable_err <= stable_err + 1;
      hold    <= mem_req && !mem_ack;
      h_addr  <= mem_addr;
      h_wdata <= mem_wdata;
      h_we    <= mem_we;
      h_be    <= mem_be;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One core operation: present it, hold through stalls, return data seen in the advance cycle.
  task automatic core_op(input logic we, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output int stalls);
    m_we = we; m_rd = rd; m_addr = addr; m_wdata = wdata; m_be = be;
    stalls = 0;
    @(negedge clk);
    while (m_stall && stalls < LIMIT) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= LIMIT) begin
      n_chk++;
      $display("FAIL stall_bound: still stalled after %0d cycles, want release", stalls);
    end
    rdata = m_rdata;
    @(posedge clk);
    #1;
    m_we = 1'b0; m_rd = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_m_rdata"}, m_rdata, 32'h0);
    check({tag, "_m_stall"}, 32'(m_stall), 32'h0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    logic [31:0] exp_rdata;
    int          exp_stalls;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] model_mem [0:63];
  logic [31:0] rd_v, a, wd;
  logic [3:0]  be_r;
  int          st_v, rd_before, sel, w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,          4'h0, 0, 32'h1234_5678, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0022, 32'hAABB_CCDD, 4'h3, 3, 32'h0,          0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,          4'h0, 1, 32'h0000_CCDD, 3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0024, 32'h1122_3344, 4'hF, 0, 32'h0,          0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0027, 32'h9900_0000, 4'h8, 2, 32'h0,          0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0024, 32'h0,          4'h0, 2, 32'h9922_3344, 4};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,          4'h0, 0, 32'h1234_5678, 2};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h4, 0, 32'h0,          0};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,          4'h0, 0, 32'h00FF_CCDD, 2};

    reset = 1'b0; m_we = 1'b0; m_rd = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    idle(1);

    // Directed table; each row starts with an empty buffer.
    for (int i = 0; i < 9; i++) begin
      ack_delay = vecs[i].delay;
      core_op(vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd_v, st_v);
      check($sformatf("vec%0d_stall", i), 32'(st_v), 32'(vecs[i].exp_stalls));
      if (vecs[i].rd && !vecs[i].we)
        check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rdata);
      idle(8);
      check($sformatf("vec%0d_mem_addr", i), last_addr, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("vec%0d_mem_we", i), 32'(last_we), 32'(vecs[i].we));
      check($sformatf("vec%0d_mem_be", i), 32'(last_be), vecs[i].we ? 32'(vecs[i].be) : 32'h0);
      check($sformatf("vec%0d_req_len", i), 32'(last_len), 32'(vecs[i].delay + 1));
    end

    // Back-to-back stores: the second waits for the first ack.
    ack_delay = 3;
    core_op(1'b1, 1'b0, 32'h0000_0022, 32'hAABB_CCDD, 4'h3, rd_v, st_v);
    check("b2b_st1_stall", 32'(st_v), 32'd0);
    core_op(1'b1, 1'b0, 32'h0000_0028, 32'h0BAD_F00D, 4'hF, rd_v, st_v);
    check("b2b_st2_stall", 32'(st_v), 32'd4);
    idle(8);
    ack_delay = 0;
    core_op(1'b0, 1'b1, 32'h0000_0028, 32'h0, 4'h0, rd_v, st_v);
    check("b2b_ld_rdata", rd_v, 32'h0BAD_F00D);

    // Store then load to another word: drain completes before the read starts.
    ack_delay = 2;
    core_op(1'b1, 1'b0, 32'h0000_0030, 32'h5555_AAAA, 4'hF, rd_v, st_v);
    core_op(1'b0, 1'b1, 32'h0000_0024, 32'h0, 4'h0, rd_v, st_v);
    check("st_ld_stall", 32'(st_v), 32'd8);
    check("st_ld_rdata", rd_v, 32'h9922_3344);
    check("st_ld_order", 32'(last_wr_ack_cyc < last_rd_start_cyc), 32'd1);
    idle(4);

    // Full-word store followed by a load of the same word.
    ack_delay = 2;
    rd_before = rd_starts;
    core_op(1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_0001, 4'hF, rd_v, st_v);
    core_op(1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'h0, rd_v, st_v);
    check("fwd_rdata", rd_v, 32'hCAFE_0001);
    idle(8);
`ifdef M_BRIDGE_FWD_EN
    check("fwd_stall", 32'(st_v), 32'd1);
    check("fwd_no_read", 32'(rd_starts - rd_before), 32'd0);
`else
    check("fwd_stall", 32'(st_v), 32'd8);
    check("fwd_read_issued", 32'(rd_starts - rd_before), 32'd1);
`endif

    // Memory never answers: load and store are abandoned, bus_err sticks.
    ack_delay = 255;
    core_op(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, rd_v, st_v);
    check("to_ld_stall", 32'(st_v), 32'(TO + 1));
    check("to_ld_rdata", rd_v, 32'h0);
    check("to_bus_err", 32'(bus_err), 32'd1);
    core_op(1'b1, 1'b0, 32'h0000_0050, 32'h0000_0077, 4'hF, rd_v, st_v);
    idle(10);
    ack_delay = 0;
    core_op(1'b0, 1'b1, 32'h0000_0050, 32'h0, 4'h0, rd_v, st_v);
    check("to_st_dropped", rd_v, init_word(20));
    check("to_after_stall", 32'(st_v), 32'd2);
    check("to_bus_err_sticky", 32'(bus_err), 32'd1);

    // Reset in the middle of an outstanding read.
    ack_delay = 255;
    m_rd = 1'b1; m_addr = 32'h0000_0010;
    @(negedge clk);
    @(negedge clk);
    check("rstrd_req_before", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0; m_rd = 1'b0;
    #1;
    check_reset_vals("rstrd");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    ack_delay = 0;
    core_op(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, rd_v, st_v);
    check("rstrd_ld_rdata", rd_v, 32'h1234_5678);
    check("rstrd_ld_stall", 32'(st_v), 32'd2);

    // Random traffic against a program-order memory model.
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      w = $urandom_range(0, 15);
      a = 32'(w * 4) | 32'($urandom_range(0, 3));
      ack_delay = $urandom_range(0, 2);
      if (sel < 2) begin
        idle(1);
      end else if (sel < 5) begin
        wd = $urandom;
        be_r = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(1, 15));
        core_op(1'b1, sel == 4, a, wd, be_r, rd_v, st_v);
        for (int b = 0; b < 4; b++)
          if (be_r[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        core_op(1'b0, 1'b1, a, 32'h0, 4'h0, rd_v, st_v);
        check($sformatf("rand%0d_rdata", k), rd_v, model_mem[w]);
      end
    end
    idle(12);
    for (int i = 0; i < 16; i++)
      check($sformatf("final_mem%0d", i), mem[i], model_mem[i]);
    check("rand_bus_err", 32'(bus_err), 32'd0);
    check("req_stable", 32'(stable_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
